// File: rtl/pwm_transmitter.sv
// Four-channel ESC pulse generator. Each frame starts with a one-cycle LATCH and then runs a us-resolution RUN phase.
// Optional macro PWM_FAILSAFE_EN: after FAILSAFE_FRAMES frames without new widths, fall back to MIN_US.
module pwm_transmitter #(
  parameter int CLK_DIV         = 50,
  parameter int FRAME_US        = 2500,
  parameter int MIN_US          = 1000,
  parameter int MAX_US          = 2000,
  parameter int FAILSAFE_FRAMES = 10
) (
  input  logic        clk_system,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        load,
  input  logic [63:0] widths,
  output logic        load_ready,
  output logic [3:0]  pwm_out,
  output logic        frame_start,
  output logic        failsafe
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int US_W  = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
  localparam logic [15:0] MIN_W = 16'(MIN_US);
  localparam logic [15:0] MAX_W = 16'(MAX_US);

  generate
    if (CLK_DIV < 1 || FRAME_US < 2 || MIN_US > MAX_US || MAX_US >= FRAME_US ||
        MAX_US > 65535 || FAILSAFE_FRAMES < 1) begin : g_bad_params
      $error("pwm_transmitter: inconsistent timing parameters");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, LATCH, RUN} state_t;

  state_t            state_reg, state_next;
  logic [DIV_W-1:0]  div_cnt_reg, div_cnt_next;
  logic [US_W-1:0]   us_cnt_reg, us_cnt_next;
  logic [3:0][15:0]  active_reg, active_next;
  logic [3:0][15:0]  pending_reg, pending_next;
  logic [3:0][15:0]  widths_clamped;
  logic              pending_full_reg, pending_full_next;
  logic [3:0]        pwm_reg, pwm_next;
  logic              tick, frame_wrap, accept;

  assign tick        = (div_cnt_reg == DIV_W'(CLK_DIV - 1));
  assign frame_wrap  = tick && (us_cnt_reg == US_W'(FRAME_US - 1));
  // The LATCH cycle empties the buffer, so it can take a new load in the same cycle.
  assign load_ready  = !pending_full_reg || (state_reg == LATCH);
  assign accept      = load && load_ready;
  assign frame_start = (state_reg == LATCH);
  assign pwm_out     = pwm_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chan
      assign widths_clamped[gi] = (widths[16*gi +: 16] < MIN_W) ? MIN_W :
                                  (widths[16*gi +: 16] > MAX_W) ? MAX_W : widths[16*gi +: 16];
      // Registered, using the widths being latched, so the first edge lands 1 cycle after LATCH.
      assign pwm_next[gi] = (state_reg != IDLE) && (32'(us_cnt_reg) < 32'(active_next[gi]));
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    div_cnt_next = div_cnt_reg;
    us_cnt_next  = us_cnt_reg;
    case (state_reg)
      IDLE: begin
        div_cnt_next = '0;
        us_cnt_next  = '0;
        if (enable) state_next = LATCH;
      end
      LATCH, RUN: begin
        if (tick) begin
          div_cnt_next = '0;
          us_cnt_next  = (us_cnt_reg == US_W'(FRAME_US - 1)) ? '0 : us_cnt_reg + US_W'(1);
        end else begin
          div_cnt_next = div_cnt_reg + DIV_W'(1);
        end
        if (state_reg == LATCH) state_next = RUN;
        else if (frame_wrap)    state_next = enable ? LATCH : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef PWM_FAILSAFE_EN
  localparam int FS_W = $clog2(FAILSAFE_FRAMES + 1);
  localparam logic [FS_W-1:0] FS_MAX = FS_W'(FAILSAFE_FRAMES);

  logic [FS_W-1:0] frame_cnt_reg, frame_cnt_next;
  logic            failsafe_reg, failsafe_next;

  assign failsafe = failsafe_reg;
`else
  assign failsafe = 1'b0;
`endif

  always_comb begin
    active_next       = active_reg;
    pending_next      = pending_reg;
    pending_full_next = pending_full_reg;
`ifdef PWM_FAILSAFE_EN
    frame_cnt_next    = frame_cnt_reg;
    failsafe_next     = failsafe_reg;
`endif
    if (state_reg == LATCH) begin
      if (pending_full_reg) begin
        active_next       = pending_reg;
        pending_full_next = 1'b0;
`ifdef PWM_FAILSAFE_EN
        frame_cnt_next    = '0;
        failsafe_next     = 1'b0;
`endif
      end
`ifdef PWM_FAILSAFE_EN
      else begin
        // Counter saturates so failsafe keeps forcing MIN_US until real widths arrive.
        if (frame_cnt_reg != FS_MAX) frame_cnt_next = frame_cnt_reg + FS_W'(1);
        if (32'(frame_cnt_reg) + 32'd1 >= 32'(FAILSAFE_FRAMES)) begin
          failsafe_next = 1'b1;
          active_next   = {4{MIN_W}};
        end
      end
`endif
    end
    if (accept) begin
      pending_next      = widths_clamped;
      pending_full_next = 1'b1;
    end
  end

  always_ff @(posedge clk_system or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      div_cnt_reg      <= '0;
      us_cnt_reg       <= '0;
      active_reg       <= {4{MIN_W}};
      pending_reg      <= '0;
      pending_full_reg <= 1'b0;
      pwm_reg          <= '0;
    end else begin
      state_reg        <= state_next;
      div_cnt_reg      <= div_cnt_next;
      us_cnt_reg       <= us_cnt_next;
      active_reg       <= active_next;
      pending_reg      <= pending_next;
      pending_full_reg <= pending_full_next;
      pwm_reg          <= pwm_next;
    end
  end

`ifdef PWM_FAILSAFE_EN
  always_ff @(posedge clk_system or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_reg <= '0;
      failsafe_reg  <= 1'b0;
    end else begin
      frame_cnt_reg <= frame_cnt_next;
      failsafe_reg  <= failsafe_next;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_transmitter.sv
// Directed bench for pwm_transmitter on a scaled timebase: 4 cycles/us, 40 us frames, widths clamped to 10..20 us.
module tb_pwm_transmitter;

  localparam int CLK_DIV  = 4;
  localparam int FRAME_US = 40;
  localparam int FRAME    = CLK_DIV * FRAME_US;  // 160 cycles per frame
`ifdef PWM_FAILSAFE_EN
  localparam int       J_HI = 40;
  localparam logic     J_FS = 1'b1;
`else
  localparam int       J_HI = 72;
  localparam logic     J_FS = 1'b0;
`endif

  logic        clk_system = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        load;
  logic [63:0] widths;
  logic        load_ready;
  logic [3:0]  pwm_out;
  logic        frame_start;
  logic        failsafe;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_system = ~clk_system;

  pwm_transmitter #(
    .CLK_DIV(CLK_DIV), .FRAME_US(FRAME_US), .MIN_US(10), .MAX_US(20), .FAILSAFE_FRAMES(3)
  ) dut (
    .clk_system (clk_system),
    .reset_n    (reset_n),
    .enable     (enable),
    .load       (load),
    .widths     (widths),
    .load_ready (load_ready),
    .pwm_out    (pwm_out),
    .frame_start(frame_start),
    .failsafe   (failsafe)
  );

  function automatic logic [63:0] pack4(input int c0, input int c1, input int c2, input int c3);
    return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_fs(input string tag);
    int n = 0;
    while (frame_start !== 1'b1 && n < 1000) begin
      @(negedge clk_system);
      n++;
    end
    check({tag, "_frame_start_seen"}, 64'(frame_start), 64'd1);
  endtask

  // Called at the negedge of a LATCH cycle; runs one whole frame, counting high cycles per channel.
  task automatic run_frame(input string tag,
                           input int la1, input logic [63:0] v1, input logic r1,
                           input int la2, input logic [63:0] v2, input logic r2,
                           input int drop_at,
                           input int e0, input int e1, input int e2, input int e3,
                           input logic exp_fs, input logic exp_next_start);
    int hi [4];
    for (int i = 0; i < 4; i++) hi[i] = 0;
    for (int k = 0; k < FRAME; k++) begin
      load = 1'b0;
      if (k == drop_at) enable = 1'b0;
      if (k == la1) begin
        check({tag, "_ready1"}, 64'(load_ready), 64'(r1));
        load = 1'b1; widths = v1;
      end
      if (k == la2) begin
        check({tag, "_ready2"}, 64'(load_ready), 64'(r2));
        load = 1'b1; widths = v2;
      end
      if ((la1 >= 0 && k == la1 + 1) || (la2 >= 0 && k == la2 + 1))
        check({tag, "_ready_drop"}, 64'(load_ready), 64'd0);
      if (k == 0) check({tag, "_pwm_in_latch"}, 64'(pwm_out), 64'd0);
      if (k == 1) check({tag, "_first_edge"}, 64'(pwm_out), 64'hf);
      if (k == 5) check({tag, "_failsafe"}, 64'(failsafe), 64'(exp_fs));
      for (int i = 0; i < 4; i++) hi[i] += int'(pwm_out[i]);
      @(negedge clk_system);
    end
    load = 1'b0;
    check({tag, "_hi0"}, 64'(hi[0]), 64'(e0));
    check({tag, "_hi1"}, 64'(hi[1]), 64'(e1));
    check({tag, "_hi2"}, 64'(hi[2]), 64'(e2));
    check({tag, "_hi3"}, 64'(hi[3]), 64'(e3));
    check({tag, "_next_start"}, 64'(frame_start), 64'(exp_next_start));
    $display("frame %s: hi=%0d/%0d/%0d/%0d failsafe=%0b", tag, hi[0], hi[1], hi[2], hi[3], failsafe);
  endtask

  initial begin
    logic quiet;
    reset_n = 1'b0; enable = 1'b0; load = 1'b0; widths = '0;
    #1;
    check("rst_pwm", 64'(pwm_out), 64'd0);
    check("rst_frame_start", 64'(frame_start), 64'd0);
    check("rst_failsafe", 64'(failsafe), 64'd0);
    check("rst_load_ready", 64'(load_ready), 64'd1);
    repeat (2) @(negedge clk_system);
    reset_n = 1'b1;
    @(negedge clk_system);
    check("idle_pwm", 64'(pwm_out), 64'd0);
    check("idle_frame_start", 64'(frame_start), 64'd0);
    enable = 1'b1;
    wait_fs("A");

    // Frames A/B at MIN widths; load mid-frame in B must not disturb B.
    run_frame("A", -1, '0, 1'b0, -1, '0, 1'b0, -1, 40, 40, 40, 40, 1'b0, 1'b1);
    run_frame("B", 30, pack4(15, 12, 20, 10), 1'b1, -1, '0, 1'b0, -1, 40, 40, 40, 40, 1'b0, 1'b1);
    // C uses B's load; clamp load captured for D.
    run_frame("C", 30, pack4(0, 100, 9, 21), 1'b1, -1, '0, 1'b0, -1, 60, 48, 80, 40, 1'b0, 1'b1);
    // Second load while buffer full is ignored.
    run_frame("D", 20, pack4(15, 15, 15, 15), 1'b1, 40, pack4(12, 12, 12, 12), 1'b0, -1,
              40, 80, 40, 80, 1'b0, 1'b1);
    run_frame("E", 10, pack4(11, 11, 11, 11), 1'b1, -1, '0, 1'b0, -1, 60, 60, 60, 60, 1'b0, 1'b1);
    // Load coincident with LATCH while full: old pending used now, new one next frame.
    run_frame("F", 0, pack4(18, 18, 18, 18), 1'b1, -1, '0, 1'b0, -1, 44, 44, 44, 44, 1'b0, 1'b1);
    run_frame("G", -1, '0, 1'b0, -1, '0, 1'b0, -1, 72, 72, 72, 72, 1'b0, 1'b1);
    run_frame("H", -1, '0, 1'b0, -1, '0, 1'b0, -1, 72, 72, 72, 72, 1'b0, 1'b1);
    run_frame("I", -1, '0, 1'b0, -1, '0, 1'b0, -1, 72, 72, 72, 72, 1'b0, 1'b1);
    run_frame("J", 50, pack4(16, 16, 16, 16), 1'b1, -1, '0, 1'b0, -1, J_HI, J_HI, J_HI, J_HI, J_FS, 1'b1);
    run_frame("K", -1, '0, 1'b0, -1, '0, 1'b0, -1, 64, 64, 64, 64, 1'b0, 1'b1);
    // enable dropped mid-frame: frame completes, then idle.
    run_frame("L", -1, '0, 1'b0, -1, '0, 1'b0, 50, 64, 64, 64, 64, 1'b0, 1'b0);
    quiet = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (pwm_out !== 4'h0 || frame_start !== 1'b0) quiet = 1'b0;
      @(negedge clk_system);
    end
    check("idle_after_disable", 64'(quiet), 64'd1);

    // Reset mid-pulse drops outputs asynchronously and restores MIN widths.
    enable = 1'b1;
    wait_fs("M");
    repeat (10) @(negedge clk_system);
    check("mid_pulse_high", 64'(pwm_out), 64'hf);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_pwm", 64'(pwm_out), 64'd0);
    check("async_rst_ready", 64'(load_ready), 64'd1);
    check("async_rst_frame_start", 64'(frame_start), 64'd0);
    @(negedge clk_system);
    reset_n = 1'b1;
    wait_fs("N");
    run_frame("N", -1, '0, 1'b0, -1, '0, 1'b0, -1, 40, 40, 40, 40, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
